// File: rtl/damage_arbiter.sv
// -----------------------------------------------------------------------------
// damage_arbiter
//
// Shares one damage calculator between N_REQ bullet lanes. Requesting lanes are
// granted round-robin. The granted lane's bullet index, colour and the
// player-move flag are latched and handed to the calculator with a start/done
// handshake. The returned damage is subtracted from the player HP, saturating
// at zero. Reaching zero HP parks the block in DEAD until hp_reload.
//
// Optional feature (compile-time macro DAMAGE_ARBITER_IFRAME_EN):
//   A nonzero-damage hit starts an invincibility window of IFRAME_CYCLES.
//   Requests arriving inside the window are acked at once with zero damage,
//   and the calculator is not started for them.
//
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   req            per-lane hit request, held until that lane's ack
//   req_index      per-lane bullet index, lane i at [i*IDX_W +: IDX_W]
//   req_color      per-lane bullet colour, lane i at [i*3 +: 3]
//   player_move    player-moving flag, captured at grant
//   hp_reload      synchronous pulse that restores HP_INIT
//   ack            one-cycle acknowledge to the served lane
//   calc_start     one-cycle start pulse to the calculator
//   calc_index     latched index of the granted lane
//   calc_color     latched colour of the granted lane
//   calc_collide   high while a transaction is live (START..APPLY)
//   calc_move      latched player_move
//   calc_damage    calculator result, valid with calc_done
//   calc_done      calculator completion flag
//   hp             current player HP
//   dead           HP has reached zero
//   busy           FSM is not idle
//   timeout_err    sticky calculator-hang flag
// -----------------------------------------------------------------------------
module damage_arbiter #(
    parameter int unsigned N_REQ         = 4,
    parameter int unsigned IDX_W         = 3,
    parameter int unsigned DMG_W         = 8,
    parameter int unsigned HP_INIT       = 92,
    parameter int unsigned TIMEOUT       = 255,
    parameter int unsigned IFRAME_CYCLES = 60
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*IDX_W-1:0] req_index,
    input  logic [N_REQ*3-1:0]     req_color,
    input  logic                   player_move,
    input  logic                   hp_reload,
    output logic [N_REQ-1:0]       ack,
    output logic                   calc_start,
    output logic [IDX_W-1:0]       calc_index,
    output logic [2:0]             calc_color,
    output logic                   calc_collide,
    output logic                   calc_move,
    input  logic [DMG_W-1:0]       calc_damage,
    input  logic                   calc_done,
    output logic [DMG_W-1:0]       hp,
    output logic                   dead,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [DMG_W-1:0] HP_INIT_V = DMG_W'(HP_INIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_APPLY,
        S_DEAD
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;       // last lane served
    logic [PTR_W-1:0]   grant_q, grant_d;   // lane owning the live transaction
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [2:0]         col_q, col_d;
    logic               move_q, move_d;
    logic [DMG_W-1:0]   dmg_q, dmg_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic [DMG_W-1:0]   hp_q, hp_d;
    logic               terr_q, terr_d;

    // Round-robin pick: first requesting lane strictly after the last one served.
    logic               found;
    logic [PTR_W-1:0]   pick;
    logic [PTR_W-1:0]   cand;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        found = 1'b0;
        pick  = ptr_q;
        cand  = ptr_q;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            cand = PTR_W'((int'(ptr_q) + k) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Saturating subtraction: HP never wraps below zero.
    logic [DMG_W-1:0] hp_sat;
    assign hp_sat = (hp_q > dmg_q) ? (hp_q - dmg_q) : '0;

`ifdef DAMAGE_ARBITER_IFRAME_EN
    localparam int unsigned IF_W = $clog2(IFRAME_CYCLES + 1);
    logic [IF_W-1:0] iframe_q, iframe_d;
    logic            iframe_active;
    assign iframe_active = (iframe_q != '0);
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        col_d   = col_q;
        move_d  = move_q;
        dmg_d   = dmg_q;
        wdog_d  = wdog_q;
        hp_d    = hp_q;
        terr_d  = terr_q;
`ifdef DAMAGE_ARBITER_IFRAME_EN
        iframe_d = iframe_active ? (iframe_q - IF_W'(1)) : '0;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = pick;
                    idx_d   = req_index[int'(pick)*IDX_W +: IDX_W];
                    col_d   = req_color[int'(pick)*3 +: 3];
                    move_d  = player_move;
`ifdef DAMAGE_ARBITER_IFRAME_EN
                    if (iframe_active) begin
                        // Invincible: skip the calculator, ack with no damage.
                        dmg_d   = '0;
                        state_d = S_APPLY;
                    end else begin
                        state_d = S_START;
                    end
`else
                    state_d = S_START;
`endif
                end
            end

            S_START: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (calc_done) begin
                    dmg_d   = calc_damage;
                    state_d = S_APPLY;
                end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th WAIT cycle without done: give up.
                    terr_d  = 1'b1;
                    dmg_d   = '0;
                    state_d = S_APPLY;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end

            S_APPLY: begin
                ptr_d   = grant_q;
                hp_d    = hp_sat;
                state_d = (hp_sat == '0) ? S_DEAD : S_IDLE;
`ifdef DAMAGE_ARBITER_IFRAME_EN
                if (dmg_q != '0) begin
                    iframe_d = IF_W'(IFRAME_CYCLES);
                end
`endif
            end

            S_DEAD: begin
                // Hold: requests are neither granted nor acked.
            end

            default: state_d = S_IDLE;
        endcase

        // Reload overrides any damage applied this cycle; an in-flight
        // transaction elsewhere simply carries on.
        if (hp_reload) begin
            hp_d = HP_INIT_V;
`ifdef DAMAGE_ARBITER_IFRAME_EN
            iframe_d = '0;
`endif
            if (state_q == S_DEAD || state_q == S_APPLY) begin
                state_d = S_IDLE;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= PTR_W'(N_REQ - 1);
            grant_q <= '0;
            idx_q   <= '0;
            col_q   <= '0;
            move_q  <= 1'b0;
            dmg_q   <= '0;
            wdog_q  <= '0;
            hp_q    <= HP_INIT_V;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            col_q   <= col_d;
            move_q  <= move_d;
            dmg_q   <= dmg_d;
            wdog_q  <= wdog_d;
            hp_q    <= hp_d;
            terr_q  <= terr_d;
        end
    end

`ifdef DAMAGE_ARBITER_IFRAME_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iframe_q <= '0;
        end else begin
            iframe_q <= iframe_d;
        end
    end
`endif

    // Moore outputs decoded from the state register.
    assign ack          = (state_q == S_APPLY) ? (N_REQ'(1) << grant_q) : '0;
    assign calc_start   = (state_q == S_START);
    assign calc_collide = (state_q == S_START) || (state_q == S_WAIT) || (state_q == S_APPLY);
    assign calc_index   = idx_q;
    assign calc_color   = col_q;
    assign calc_move    = move_q;
    assign hp           = hp_q;
    assign dead         = (state_q == S_DEAD);
    assign busy         = (state_q != S_IDLE);
    assign timeout_err  = terr_q;

endmodule
